mux_bus: RTL and testbench

//   Parameterised one-hot-free bus multiplexer: picks one WIDTH-bit slice of a

---
 rtl/mux_bus_if.sv | 53 +++++
 rtl/mux_bus.sv | 79 +++++++
 tb/tb_mux_bus.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mux_bus_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_bus_if
// Purpose  : Bundles the shared-path signals of the bus multiplexer.
//            master : requester side, drives packed data and selection,
//                     observes the multiplexed output.
//            slave  : multiplexer side, consumes data and selection,
//                     drives the multiplexed output.
// Signals  : data_in      WIDTH*NUM_PORTS  packed port data, port 0 in the LSBs
//            enable_port  clog2(NUM_PORTS) index of the selected port
//            valid_enable 1                1 = selection valid, 0 = drive zero
//            data_out     WIDTH            selected slice or zero
// Revision : 1.0 - initial release
// ============================================================================
interface mux_bus_if #(
    parameter int WIDTH     = 8,
    parameter int NUM_PORTS = 4
);
    // Ceiling log2, shared rule with the multiplexer so index widths agree.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int c_sel_w = clog2(NUM_PORTS);

    logic [WIDTH*NUM_PORTS-1:0] data_in;
    logic [c_sel_w-1:0]         enable_port;
    logic                       valid_enable;
    logic [WIDTH-1:0]           data_out;

    modport master (
        output data_in,
        output enable_port,
        output valid_enable,
        input  data_out
    );

    modport slave (
        input  data_in,
        input  enable_port,
        input  valid_enable,
        output data_out
    );
endinterface
`default_nettype wire

// File: rtl/mux_bus.sv
`default_nettype none
// ============================================================================
// Module   : mux_bus
// Purpose  : Selects one WIDTH-bit slice of a packed NUM_PORTS-wide bus and
//            drives it onto a single output; zero when the selection is not
//            valid or the index is out of range. Optionally registered.
// Ports    : clock  in   system clock (used only when REGISTER_OUTPUT=1)
//            reset  in   synchronous, active-low reset (registered mode only)
//            bus    slave data_in / enable_port / valid_enable / data_out
// Revision : 1.0 - initial release
// ============================================================================
module mux_bus #(
    parameter int WIDTH           = 8,
    parameter int NUM_PORTS       = 4,
    parameter int REGISTER_OUTPUT = 0
) (
    input  wire logic  clock,
    input  wire logic  reset,
    mux_bus_if.slave   bus
);
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int c_sel_w = clog2(NUM_PORTS);

    generate
        if (NUM_PORTS < 2 || WIDTH < 1) begin : g_param_check
            $error("mux_bus: NUM_PORTS must be >= 2 and WIDTH >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] w_data_out_d;

    // Compare against every real port index; an index with no matching port
    // (non-power-of-2 NUM_PORTS) simply never hits, so the default zero
    // holds and nothing from outside data_in can leak through.
    always_comb begin
        w_data_out_d = '0;
        if (bus.valid_enable) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if ({1'b0, bus.enable_port} == i[c_sel_w:0]) begin
                    w_data_out_d = bus.data_in[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    generate
        if (REGISTER_OUTPUT != 0) begin : g_reg
            logic [WIDTH-1:0] r_data_out_q;

            always_ff @(posedge clock) begin
                if (!reset) begin
                    r_data_out_q <= '0;
                end else begin
                    r_data_out_q <= w_data_out_d;
                end
            end

            assign bus.data_out = r_data_out_q;
        end else begin : g_comb
            // Clock and reset are intentionally unused in combinational mode.
            logic w_unused;
            assign w_unused = clock ^ reset;

            assign bus.data_out = w_data_out_d;
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_mux_bus.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_bus
// Purpose  : Self-checking bench for mux_bus. Three instances:
//            u_comb4 (NUM_PORTS=4, combinational), u_comb3 (NUM_PORTS=3,
//            combinational), u_reg4 (NUM_PORTS=4, registered output).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_bus;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    mux_bus_if #(.WIDTH(8), .NUM_PORTS(4)) bus4 ();
    mux_bus_if #(.WIDTH(8), .NUM_PORTS(3)) bus3 ();
    mux_bus_if #(.WIDTH(8), .NUM_PORTS(4)) busr ();

    mux_bus #(.WIDTH(8), .NUM_PORTS(4), .REGISTER_OUTPUT(0)) u_comb4 (
        .clock (clock),
        .reset (reset),
        .bus   (bus4)
    );

    mux_bus #(.WIDTH(8), .NUM_PORTS(3), .REGISTER_OUTPUT(0)) u_comb3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3)
    );

    mux_bus #(.WIDTH(8), .NUM_PORTS(4), .REGISTER_OUTPUT(1)) u_reg4 (
        .clock (clock),
        .reset (reset),
        .bus   (busr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: shift the selected slice down to bit 0 arithmetically.
    function automatic logic [7:0] model(input int nports, input logic [31:0] data,
                                         input logic valid, input int port);
        logic [31:0] masked;
        logic [31:0] shifted;
        if (!valid || port >= nports) return 8'h00;
        masked  = (nports == 4) ? data : (data & ((32'd1 << (nports * 8)) - 32'd1));
        shifted = masked >> (port * 8);
        return shifted[7:0];
    endfunction

    typedef struct {
        logic        valid;
        logic [1:0]  port;
        logic [31:0] data;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [31:0] d;
        logic        v;
        logic [1:0]  p;
        logic        rst_v;
        logic [7:0]  exp_r;

        tbl[0] = '{1'b0, 2'd0, 32'h89ABCDEF, 8'h00};
        tbl[1] = '{1'b1, 2'd1, 32'h89ABCDEF, 8'hCD};
        tbl[2] = '{1'b1, 2'd2, 32'h89ABCDEF, 8'hAB};
        tbl[3] = '{1'b1, 2'd3, 32'h89ABCDEF, 8'h89};
        tbl[4] = '{1'b1, 2'd0, 32'h89ABCDEF, 8'hEF};
        tbl[5] = '{1'b0, 2'd0, 32'h89ABCDEF, 8'h00};   // valid drop, same port
        tbl[6] = '{1'b1, 2'd3, 32'h89ABCDEF, 8'h89};   // port and valid change together
        tbl[7] = '{1'b0, 2'd2, 32'h89ABCDEF, 8'h00};   // valid low overrides in-range port
        tbl[8] = '{1'b1, 2'd0, 32'h00000000, 8'h00};

        reset             = 1'b0;
        bus4.data_in      = '0;
        bus4.enable_port  = '0;
        bus4.valid_enable = 1'b0;
        bus3.data_in      = '0;
        bus3.enable_port  = '0;
        bus3.valid_enable = 1'b0;
        busr.data_in      = 32'h89ABCDEF;
        busr.enable_port  = 2'd2;
        busr.valid_enable = 1'b1;

        // Registered instance held in reset must read zero.
        @(negedge clock);
        @(negedge clock);
        check("reg_reset", busr.data_out, 8'h00);

        // Combinational table, applied in one timestep each.
        for (int i = 0; i < 9; i++) begin
            bus4.data_in      = tbl[i].data;
            bus4.enable_port  = tbl[i].port;
            bus4.valid_enable = tbl[i].valid;
            #1;
            check($sformatf("comb_tbl%0d", i), bus4.data_out, tbl[i].exp);
        end

        // Non-power-of-2 port count: index 3 has no port.
        bus3.data_in      = 24'hABCDEF;
        bus3.enable_port  = 2'd3;
        bus3.valid_enable = 1'b1;
        #1;
        check("n3_oob", bus3.data_out, 8'h00);
        bus3.enable_port  = 2'd2;
        #1;
        check("n3_port2", bus3.data_out, 8'hAB);

        // Registered: release reset, first value one edge later.
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("reg_first", busr.data_out, 8'hAB);
        busr.enable_port = 2'd3;
        #1;
        check("reg_latency", busr.data_out, 8'hAB);
        @(negedge clock);
        check("reg_next", busr.data_out, 8'h89);

        // Reset mid-stream discards the pending value.
        busr.enable_port = 2'd1;
        reset = 1'b0;
        @(negedge clock);
        check("reg_mid_reset", busr.data_out, 8'h00);
        reset = 1'b1;
        @(negedge clock);
        check("reg_resume", busr.data_out, 8'hCD);

        // Random combinational checks; reset toggles to show it has no effect.
        for (int k = 0; k < 200; k++) begin
            d = $urandom;
            v = 1'($urandom_range(0, 1));
            p = 2'($urandom_range(0, 3));
            reset = 1'($urandom_range(0, 1));
            bus4.data_in      = d;
            bus4.enable_port  = p;
            bus4.valid_enable = v;
            bus3.data_in      = d[23:0];
            bus3.enable_port  = p;
            bus3.valid_enable = v;
            #3;
            check("rand_comb4", bus4.data_out, model(4, d, v, int'(p)));
            check("rand_comb3", bus3.data_out, model(3, {8'h00, d[23:0]}, v, int'(p)));
        end

        // Random registered checks with occasional reset.
        @(negedge clock);
        for (int k = 0; k < 200; k++) begin
            d     = $urandom;
            v     = 1'($urandom_range(0, 1));
            p     = 2'($urandom_range(0, 3));
            rst_v = ($urandom_range(0, 7) != 0);
            busr.data_in      = d;
            busr.enable_port  = p;
            busr.valid_enable = v;
            reset             = rst_v;
            exp_r = rst_v ? model(4, d, v, int'(p)) : 8'h00;
            @(negedge clock);
            check("rand_reg", busr.data_out, exp_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
